// File: rtl/hamming_decoder_stream_if.sv
// Streaming handshake bundle for the Hamming(7,4) decoder.
//   in_valid/in_ready/in_code        : upstream codeword channel
//   out_valid/out_ready/out_data     : downstream data channel
//   out_err/out_syn                  : per-word correction status
// master = the environment (drives codewords and out_ready),
// slave  = the decoder.
interface hamming_decoder_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_err;
    logic [2:0] out_syn;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_syn
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_err, out_syn
    );
endinterface

// File: rtl/hamming_decoder_stream.sv
// Streaming Hamming(7,4) single-error-correcting decoder.
// Two lock-step register stages: S1 holds the raw codeword, S2 holds the
// corrected data and status. Both stages advance together whenever the
// output is empty or being accepted, so bubbles are preserved.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        stream bundle (slave side): codeword in, data/status out
//   cnt_clr    synchronous clear of err_count (wins over increment)
//   err_count  saturating count of corrected words delivered downstream
module hamming_decoder_stream #(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hamming_decoder_stream_if.slave bus,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       err_count
);

    logic             adv;

    logic [6:0]       s1_code_q, s1_code_d;
    logic             s1_valid_q, s1_valid_d;

    logic [3:0]       s2_data_q, s2_data_d;
    logic             s2_err_q, s2_err_d;
    logic [2:0]       s2_syn_q, s2_syn_d;
    logic             s2_valid_q, s2_valid_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       syn;
    logic [6:0]       flip_mask;
    logic [6:0]       fixed_code;

    assign adv = !s2_valid_q || bus.out_ready;

    // Syndrome bit k covers every codeword position whose 1-based index has
    // bit k set, so a single flip reports its own position.
    always_comb begin
        syn[0] = s1_code_q[0] ^ s1_code_q[2] ^ s1_code_q[4] ^ s1_code_q[6];
        syn[1] = s1_code_q[1] ^ s1_code_q[2] ^ s1_code_q[5] ^ s1_code_q[6];
        syn[2] = s1_code_q[3] ^ s1_code_q[4] ^ s1_code_q[5] ^ s1_code_q[6];
        flip_mask = 7'd0;
        if (syn != 3'd0) begin
            flip_mask = 7'b1 << (syn - 3'd1);
        end
        fixed_code = s1_code_q ^ flip_mask;
    end

    always_comb begin
        s1_code_d  = s1_code_q;
        s1_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_err_d   = s2_err_q;
        s2_syn_d   = s2_syn_q;
        s2_valid_d = s2_valid_q;
        if (adv) begin
            s1_code_d  = bus.in_code;
            s1_valid_d = bus.in_valid;
            s2_data_d  = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
            s2_err_d   = (syn != 3'd0);
            s2_syn_d   = syn;
            s2_valid_d = s1_valid_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s2_valid_q && bus.out_ready && s2_err_q && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_code_q  <= 7'd0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= 4'd0;
            s2_err_q   <= 1'b0;
            s2_syn_q   <= 3'd0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_code_q  <= s1_code_d;
            s1_valid_q <= s1_valid_d;
            s2_data_q  <= s2_data_d;
            s2_err_q   <= s2_err_d;
            s2_syn_q   <= s2_syn_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_err   = s2_err_q;
    assign bus.out_syn   = s2_syn_q;
    assign err_count     = cnt_q;

endmodule

// File: tb/tb_hamming_decoder_stream.sv
// Scoreboard bench for hamming_decoder_stream. Expected words are queued
// when the decoder accepts a codeword and popped when it delivers one.
module tb_hamming_decoder_stream;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             cnt_clr;
    logic [CNT_W-1:0] err_count;

    hamming_decoder_stream_if bus ();

    hamming_decoder_stream #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         n_out = 0;
    int         model_cnt = 0;
    int         rdy_mode = 0;
    bit         ovr_en = 0;
    logic [7:0] ovr_exp = 8'd0;
    logic [7:0] exp_q[$];
    bit         stall_prev = 0;
    logic [7:0] stall_val = 8'd0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: the syndrome is the XOR of the 1-based positions of all set
    // bits; a nonzero value names the bit to invert.
    function automatic logic [7:0] ref_decode(input logic [6:0] c);
        int         s;
        logic [6:0] f;
        logic [2:0] s3;
        s = 0;
        for (int p = 1; p <= 7; p++) if (c[p-1]) s = s ^ p;
        f = c;
        if (s != 0) f[s-1] = ~f[s-1];
        s3 = 3'(s);
        return {f[6], f[5], f[4], f[2], (s != 0), s3};
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
    endfunction

    // out_ready driver, updated 2 time units after each rising edge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor / scoreboard, sampling on the falling edge
    initial begin
        logic [7:0] e;
        logic [7:0] act;
        bit         herr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_cnt = 0;
                stall_prev = 0;
                continue;
            end
            act = {bus.out_data, bus.out_err, bus.out_syn};
            check(err_count == CNT_W'(model_cnt), "err_count", 32'(err_count), 32'(model_cnt));
            check(bus.in_ready == (!bus.out_valid || bus.out_ready), "in_ready",
                  32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (stall_prev)
                check(bus.out_valid && act == stall_val, "stall_hold",
                      {23'd0, bus.out_valid, act}, {24'd1, stall_val});
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_val = act;
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ovr_en ? ovr_exp : ref_decode(bus.in_code));
            herr = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_out", 32'(act), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(act == e, "out_word", 32'(act), 32'(e));
                    herr = e[3];
                end
            end
            if (cnt_clr) model_cnt = 0;
            else if (herr && model_cnt < CNT_MAX) model_cnt++;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [6:0] code, input bit ovr, input logic [7:0] exp);
        int waitc;
        waitc = 0;
        bus.in_valid = 1'b1;
        bus.in_code = code;
        ovr_en = ovr;
        ovr_exp = exp;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waitc++;
            if (waitc > 50) begin
                check(1'b0, "accept_timeout", 32'(waitc), 32'd50);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ovr_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] code;
        logic [3:0] d;
        logic [6:0] m;
        int         n0;
        int         e1, e2;
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_code = 7'd0;
        idle(2);
        rst_n = 1'b1;

        @(negedge clk);
        check(bus.out_valid == 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'd0);
        check(bus.in_ready == 1'b1, "rst_in_ready", 32'(bus.in_ready), 32'd1);
        check(bus.out_data == 4'd0, "rst_out_data", 32'(bus.out_data), 32'd0);
        check(bus.out_err == 1'b0, "rst_out_err", 32'(bus.out_err), 32'd0);
        check(bus.out_syn == 3'd0, "rst_out_syn", 32'(bus.out_syn), 32'd0);
        check(err_count == '0, "rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;

        // Clean word: captured into S1 at the accept edge, out one edge later
        send(7'h55, 1, {4'hB, 1'b0, 3'd0});
        check(bus.out_valid == 1'b0, "lat_early", 32'(bus.out_valid), 32'd0);
        idle(1);
        check(bus.out_valid == 1'b1, "lat_valid", 32'(bus.out_valid), 32'd1);
        check(bus.out_data == 4'hB, "lat_data", 32'(bus.out_data), 32'hB);
        idle(1);
        check(err_count == '0, "clean_cnt", 32'(err_count), 32'd0);

        send(7'h45, 1, {4'hB, 1'b1, 3'd5});
        send(7'h01, 1, {4'h0, 1'b1, 3'd1});

        // Sweep every data value with no error and each single-bit flip
        for (int dv = 0; dv < 16; dv++) begin
            for (int f = 0; f < 8; f++) begin
                d = 4'(dv);
                m = (f == 0) ? 7'd0 : 7'(1 << (f - 1));
                send(enc(d) ^ m, 1, {d, (f != 0), 3'(f)});
            end
        end
        idle(4);

        // Backpressure mid-stream
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    d = 4'($urandom_range(0, 15));
                    m = 7'(1 << $urandom_range(0, 6));
                    send(enc(d) ^ m, 1, {d, 1'b1, 3'd0} | 8'(ref_decode(enc(d) ^ m) & 8'h07));
                end
            end
            begin
                idle(3);
                rdy_mode = 2;
                idle(3);
                rdy_mode = 0;
            end
        join
        idle(6);
        check(n_out - n0 == 6, "bp_count", 32'(n_out - n0), 32'd6);

        // Saturation and clear priority
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        check(err_count == '0, "clr_idle", 32'(err_count), 32'd0);
        for (int i = 0; i < 5; i++) send(7'h45, 1, {4'hB, 1'b1, 3'd5});
        idle(4);
        check(err_count == CNT_W'(CNT_MAX), "cnt_sat", 32'(err_count), 32'(CNT_MAX));
        send(7'h45, 1, {4'hB, 1'b1, 3'd5});
        idle(1);
        check(bus.out_valid && bus.out_err, "clr_setup", {bus.out_valid, bus.out_err}, 32'd3);
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        check(err_count == '0, "clr_priority", 32'(err_count), 32'd0);

        // Reset with two words in flight
        send(7'h45, 1, {4'hB, 1'b1, 3'd5});
        idle(3);
        rdy_mode = 2;
        idle(1);
        send(7'h45, 1, {4'hB, 1'b1, 3'd5});
        send(enc(4'h6), 1, {4'h6, 1'b0, 3'd0});
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rdy_mode = 0;
        check(bus.out_valid == 1'b0, "rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check(err_count == '0, "rst_mid_cnt", 32'(err_count), 32'd0);
        check(bus.in_ready == 1'b1, "rst_mid_ready", 32'(bus.in_ready), 32'd1);
        n0 = n_out;
        idle(6);
        check(n_out == n0, "rst_no_emit", 32'(n_out - n0), 32'd0);

        // Randomized traffic against the reference model
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            cnt_clr = ($urandom_range(0, 19) == 0);
            d = 4'($urandom_range(0, 15));
            code = enc(d);
            e1 = $urandom_range(0, 9);
            if (e1 >= 1 && e1 <= 7) begin
                code[e1-1] = ~code[e1-1];
            end else if (e1 >= 8) begin
                e1 = $urandom_range(0, 6);
                e2 = (e1 + $urandom_range(1, 6)) % 7;
                code[e1] = ~code[e1];
                code[e2] = ~code[e2];
            end
            send(code, 0, 8'd0);
        end
        cnt_clr = 1'b0;
        rdy_mode = 0;
        idle(6);
        check(exp_q.size() == 0, "drain_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
